// File: rtl/sdram_wb_bridge.sv
// Wishbone-to-sdram_top bridge: reset stretch, init gating, one request per bus cycle, watchdog.
// States: HOLD ctl reset held | INIT wait init_done | IDLE accept stb | REQ request out | DONE ack to bus
module sdram_wb_bridge #(
  parameter int RST_DELAY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk_p,
  input  logic        sdram_reset,
  input  logic        sdram_stb,
  input  logic        sdram_we,
  input  logic [1:0]  sdram_sel,
  input  logic [21:1] sdram_adr,
  input  logic [15:0] sdram_out,
  output logic [15:0] sdram_dat,
  output logic        sdram_ack,
  output logic        sdram_ready,
  output logic        sdram_err,
  output logic        ctl_rst_n,
  output logic        ctl_wr_req,
  output logic        ctl_rd_req,
  input  logic        ctl_wr_ack,
  input  logic        ctl_rd_ack,
  output logic [21:0] ctl_addr,
  output logic [15:0] ctl_wdata,
  input  logic [15:0] ctl_rdata,
  output logic        ctl_udqm,
  output logic        ctl_ldqm,
  input  logic        ctl_init_done
);

  localparam logic [2:0] S_HOLD = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_IDLE = 3'd2;
  localparam logic [2:0] S_REQ  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] DLY_LAST = 4'(RST_DELAY);
  localparam logic [9:0] WD_LAST  = 10'(TIMEOUT - 1);

  logic [2:0] state;
  logic [3:0] dly_cnt;
  logic [9:0] wd_cnt;
  logic       is_write;
  logic       issued;
  logic       match_ack;

  assign match_ack = is_write ? ctl_wr_ack : ctl_rd_ack;
  assign sdram_ack = sdram_stb & (state == S_DONE);

  always_ff @(posedge clk_p) begin
    if (sdram_reset) begin
      state       <= S_HOLD;
      dly_cnt     <= 4'd0;
      wd_cnt      <= 10'd0;
      is_write    <= 1'b0;
      issued      <= 1'b0;
      ctl_rst_n   <= 1'b0;
      ctl_wr_req  <= 1'b0;
      ctl_rd_req  <= 1'b0;
      ctl_udqm    <= 1'b0;
      ctl_ldqm    <= 1'b0;
      ctl_addr    <= 22'd0;
      ctl_wdata   <= 16'd0;
      sdram_dat   <= 16'd0;
      sdram_ready <= 1'b0;
      sdram_err   <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (dly_cnt == DLY_LAST) begin
            ctl_rst_n <= 1'b1;
            state     <= S_INIT;
          end else begin
            dly_cnt <= dly_cnt + 4'd1;
          end
        end
        S_INIT: begin
          if (ctl_init_done) begin
            sdram_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (sdram_stb) begin
            ctl_addr  <= {1'b0, sdram_adr};
            ctl_wdata <= sdram_out;
            is_write  <= sdram_we;
            ctl_udqm  <= sdram_we & ~sdram_sel[1];
            ctl_ldqm  <= sdram_we & ~sdram_sel[0];
            wd_cnt    <= 10'd0;
            issued    <= 1'b0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          // The request goes out one cycle after capture; acks before that are not ours.
          if (issued && match_ack) begin
            ctl_wr_req <= 1'b0;
            ctl_rd_req <= 1'b0;
            if (!is_write) sdram_dat <= ctl_rdata;
            state <= S_DONE;
          end else if (wd_cnt == WD_LAST) begin
            ctl_wr_req <= 1'b0;
            ctl_rd_req <= 1'b0;
            sdram_err  <= 1'b1;
            if (!is_write) sdram_dat <= 16'hFFFF;
            state <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 10'd1;
            if (!issued) begin
              issued     <= 1'b1;
              ctl_wr_req <= is_write;
              ctl_rd_req <= ~is_write;
            end
          end
        end
        S_DONE: begin
          if (!sdram_stb) state <= S_IDLE;
        end
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule
